// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter among N_SRC
// reply FIFOs. Each granted message goes out as
// prefix, address, length, payload, xor checksum.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | no frame in flight; grant the next requester from rr_q
// ST_PREFIX  | presenting PREFIX
// ST_ADDR    | presenting BASE_ADDR + cur_src
// ST_LEN     | presenting latched length
// ST_PAYLOAD | presenting the show-ahead byte of the granted FIFO
// ST_CRC     | presenting xor of address, length and payload
module uart_tx_arbiter #(
  parameter int          N_SRC     = 8,
  parameter logic [7:0]  PREFIX    = 8'hDD,
  parameter logic [7:0]  BASE_ADDR = 8'h10,
  localparam int         SW        = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_SRC-1:0]   have_msg,
  input  logic [8*N_SRC-1:0] len_bus,
  input  logic [8*N_SRC-1:0] data_bus,
  output logic [N_SRC-1:0]   rdreq,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic [SW-1:0]      cur_src
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PREFIX, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CRC
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cur_src_q, cur_src_d;
  logic [SW-1:0] rr_q, rr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    hdr_q, hdr_d;
  logic          tx_valid_q, tx_valid_d;

  logic          accept;
  logic          gnt_found;
  logic [SW-1:0] gnt_idx;
  logic [7:0]    gnt_len;
  logic [7:0]    pay_byte;
  logic [7:0]    addr_byte;
  int            idx;

  assign accept    = tx_valid_q & tx_ready;
  assign addr_byte = BASE_ADDR + 8'(cur_src_q);

  // Round-robin search from rr_q upward with wrap, plus the granted length
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_len   = '0;
    idx       = 0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!gnt_found && have_msg[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = SW'(idx);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (gnt_idx == SW'(i)) gnt_len = len_bus[8*i +: 8];
    end
  end

  // Show-ahead byte of the granted source
  always_comb begin
    pay_byte = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cur_src_q == SW'(i)) pay_byte = data_bus[8*i +: 8];
    end
  end

  // Next-state and framing; header bytes are preloaded into hdr_q one state early
  always_comb begin
    state_d    = state_q;
    cur_src_d  = cur_src_q;
    rr_d       = rr_q;
    len_d      = len_q;
    rem_d      = rem_q;
    csum_d     = csum_q;
    hdr_d      = hdr_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_found) begin
          cur_src_d  = gnt_idx;
          len_d      = gnt_len;
          csum_d     = '0;
          hdr_d      = PREFIX;
          tx_valid_d = 1'b1;
          state_d    = ST_PREFIX;
        end
      end
      ST_PREFIX: begin
        if (accept) begin
          hdr_d   = addr_byte;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (accept) begin
          csum_d  = csum_q ^ addr_byte;
          hdr_d   = len_q;
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (accept) begin
          csum_d = csum_q ^ len_q;
          rem_d  = len_q;
          if (len_q != 8'd0) begin
            state_d = ST_PAYLOAD;
          end else begin
            hdr_d   = csum_q ^ len_q;
            state_d = ST_CRC;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          csum_d = csum_q ^ pay_byte;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) begin
            hdr_d   = csum_q ^ pay_byte;
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (accept) begin
          rr_d       = (cur_src_q == SW'(N_SRC - 1)) ? '0 : cur_src_q + SW'(1);
          hdr_d      = '0;
          tx_valid_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: begin
        hdr_d      = '0;
        tx_valid_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any frame in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_src_q  <= '0;
      rr_q       <= '0;
      len_q      <= '0;
      rem_q      <= '0;
      csum_q     <= '0;
      hdr_q      <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_src_q  <= cur_src_d;
      rr_q       <= rr_d;
      len_q      <= len_d;
      rem_q      <= rem_d;
      csum_q     <= csum_d;
      hdr_q      <= hdr_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  // FIFO pop on each accepted payload byte; suppressed while reset is asserted
  always_comb begin
    rdreq = '0;
    if (state_q == ST_PAYLOAD && accept && !rst) rdreq[cur_src_q] = 1'b1;
  end

  assign tx_data  = (state_q == ST_PAYLOAD) ? pay_byte : hdr_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign cur_src  = cur_src_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a show-ahead FIFO model per source.
module tb_uart_tx_arbiter;
  localparam int N = 8;

  logic           clk;
  logic           rst;
  logic [N-1:0]   have_msg;
  logic [8*N-1:0] len_bus;
  logic [8*N-1:0] data_bus;
  logic [N-1:0]   rdreq;
  logic [7:0]     tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic           busy;
  logic [2:0]     cur_src;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [N][256];
  logic [7:0] rd_ptr [N] = '{default: 8'd0};
  int         rd_cnt [N] = '{default: 0};
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         grants[$];
  int         onehot_bad = 0;
  logic       busy_prev = 1'b0;

  uart_tx_arbiter #(.N_SRC(N), .PREFIX(8'hDD), .BASE_ADDR(8'h10)) dut (
    .clk(clk), .rst(rst), .have_msg(have_msg), .len_bus(len_bus),
    .data_bus(data_bus), .rdreq(rdreq), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .cur_src(cur_src)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    data_bus = '0;
    for (int i = 0; i < N; i++) data_bus[8*i +: 8] = mem[i][rd_ptr[i]];
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) if (rdreq[i]) rd_ptr[i] <= rd_ptr[i] + 8'd1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) got.push_back(tx_data);
      for (int i = 0; i < N; i++) if (rdreq[i]) rd_cnt[i] = rd_cnt[i] + 1;
      if (busy && !busy_prev) grants.push_back(int'(cur_src));
      if (!$onehot0(rdreq) || (rdreq != '0 && !(tx_valid && tx_ready))) onehot_bad = onehot_bad + 1;
    end
    busy_prev = busy;
  end

  task automatic set_len(input int s, input logic [7:0] v);
    len_bus[8*s +: 8] = v;
  endtask

  task automatic run_pkt(input int budget, output bit ok);
    bit seen;
    ok = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk); #1;
      if (busy) begin seen = 1'b1; have_msg = '0; end
      if (seen && !busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; have_msg = '0; len_bus = '0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got %0b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
    checks++; if (rdreq !== 8'h00) begin failures++; $display("FAIL reset_rdreq got %b exp 0", rdreq); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (cur_src !== 3'd0) begin failures++; $display("FAIL reset_cur_src got %0d exp 0", cur_src); end
  endtask

  task automatic test_single();
    bit ok;
    int base;
    got.delete();
    base = rd_cnt[2];
    mem[2][rd_ptr[2]] = 8'h16;
    mem[2][rd_ptr[2] + 8'd1] = 8'h1D;
    set_len(2, 8'd2);
    have_msg = 8'b0000_0100;
    run_pkt(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got %0b exp 1", ok); end
    exp_q = '{8'hDD, 8'h12, 8'h02, 8'h16, 8'h1D, 8'h1B};
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL single_len got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    checks++; if (rd_cnt[2] - base != 2) begin failures++; $display("FAIL single_rdreq got %0d exp 2", rd_cnt[2] - base); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got %0b exp 0", busy); end
  endtask

  task automatic test_zero_len();
    bit ok;
    int base;
    got.delete();
    base = 0;
    for (int i = 0; i < N; i++) base += rd_cnt[i];
    set_len(0, 8'd0);
    have_msg = 8'b0000_0001;
    run_pkt(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL zero_timeout got %0b exp 1", ok); end
    exp_q = '{8'hDD, 8'h10, 8'h00, 8'h10};
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL zero_len got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL zero_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    for (int i = 0; i < N; i++) base -= rd_cnt[i];
    checks++; if (base != 0) begin failures++; $display("FAIL zero_rdreq got %0d exp 0", -base); end
  endtask

  task automatic test_round_robin();
    int gexp[4];
    bit done;
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    got.delete(); grants.delete();
    mem[0][rd_ptr[0]] = 8'hA1; mem[0][rd_ptr[0] + 8'd1] = 8'hA2;
    mem[7][rd_ptr[7]] = 8'hB1; mem[7][rd_ptr[7] + 8'd1] = 8'hB2;
    set_len(0, 8'd1); set_len(7, 8'd1);
    have_msg = 8'b1000_0001;
    done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (grants.size() >= 4) have_msg = '0;
      if (grants.size() >= 4 && !busy) begin done = 1'b1; break; end
    end
    have_msg = '0;
    checks++; if (!done) begin failures++; $display("FAIL rr_timeout got %0d grants exp 4", grants.size()); end
    gexp = '{0, 7, 0, 7};
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      checks++; if (grants[i] != gexp[i]) begin failures++; $display("FAIL rr_grant%0d got %0d exp %0d", i, grants[i], gexp[i]); end
    end
    exp_q = '{8'hDD, 8'h10, 8'h01, 8'hA1, 8'hB0, 8'hDD, 8'h17, 8'h01, 8'hB1, 8'hA7,
              8'hDD, 8'h10, 8'h01, 8'hA2, 8'hB3, 8'hDD, 8'h17, 8'h01, 8'hB2, 8'hA4};
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL rr_len got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL rr_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit seen, done, stall_prev;
    logic [7:0] data_prev;
    int base;
    got.delete();
    base = rd_cnt[5];
    for (int k = 0; k < 64; k++) mem[5][rd_ptr[5] + 8'(k)] = 8'(k + 1);
    set_len(5, 8'd64);
    tx_ready = 1'b0;
    have_msg = 8'b0010_0000;
    seen = 1'b0; done = 1'b0; stall_prev = 1'b0; data_prev = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (stall_prev) begin
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== data_prev) begin
          failures++; $display("FAIL bp_stall_hold got v=%0b d=%h exp v=1 d=%h", tx_valid, tx_data, data_prev);
        end
      end
      if (busy) begin seen = 1'b1; have_msg = '0; end
      if (seen && !busy) begin done = 1'b1; break; end
      tx_ready = (c < 12) ? 1'b0 : 1'($urandom_range(0, 1));
      stall_prev = tx_valid && !tx_ready;
      data_prev = tx_data;
    end
    tx_ready = 1'b1;
    checks++; if (!done) begin failures++; $display("FAIL bp_timeout got %0b exp 1", done); end
    exp_q = '{8'hDD, 8'h15, 8'h40};
    for (int k = 0; k < 64; k++) exp_q.push_back(8'(k + 1));
    exp_q.push_back(8'h15);
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL bp_len got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL bp_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    checks++; if (rd_cnt[5] - base != 64) begin failures++; $display("FAIL bp_rdreq got %0d exp 64", rd_cnt[5] - base); end
  endtask

  task automatic test_late_request();
    bit done, changed;
    int b1, b3;
    got.delete(); grants.delete();
    b1 = rd_cnt[1]; b3 = rd_cnt[3];
    mem[1][rd_ptr[1]] = 8'h31; mem[1][rd_ptr[1] + 8'd1] = 8'h32; mem[1][rd_ptr[1] + 8'd2] = 8'h33;
    mem[3][rd_ptr[3]] = 8'h44;
    set_len(1, 8'd3);
    have_msg = 8'b0000_0010;
    done = 1'b0; changed = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (!changed && rd_cnt[1] > b1) begin
        have_msg = 8'b0000_1000;
        set_len(1, 8'd7); set_len(3, 8'd1);
        changed = 1'b1;
      end
      if (grants.size() >= 2) have_msg = '0;
      if (grants.size() >= 2 && !busy) begin done = 1'b1; break; end
    end
    have_msg = '0;
    checks++; if (!done) begin failures++; $display("FAIL late_timeout got %0d grants exp 2", grants.size()); end
    checks++; if (grants.size() < 2 || grants[0] != 1 || grants[1] != 3) begin failures++; $display("FAIL late_grants got %p exp 1,3", grants); end
    exp_q = '{8'hDD, 8'h11, 8'h03, 8'h31, 8'h32, 8'h33, 8'h22, 8'hDD, 8'h13, 8'h01, 8'h44, 8'h56};
    checks++; if (got.size() != exp_q.size()) begin failures++; $display("FAIL late_len got %0d exp %0d", got.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== exp_q[i]) begin failures++; $display("FAIL late_byte%0d got %h exp %h", i, got[i], exp_q[i]); end
    end
    checks++; if (rd_cnt[1] - b1 != 3 || rd_cnt[3] - b3 != 1) begin failures++; $display("FAIL late_rdreq got %0d,%0d exp 3,1", rd_cnt[1] - b1, rd_cnt[3] - b3); end
  endtask

  task automatic test_reset_mid_payload();
    bit ok, hit;
    int b4;
    got.delete(); grants.delete();
    b4 = rd_cnt[4];
    for (int k = 0; k < 6; k++) mem[4][rd_ptr[4] + 8'(k)] = 8'(8'h51 + k);
    set_len(4, 8'd6);
    have_msg = 8'b0001_0000;
    hit = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (busy) have_msg = '0;
      if (rd_cnt[4] - b4 == 3) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach got %0d exp 3", rd_cnt[4] - b4); end
    exp_q = '{8'hDD, 8'h14, 8'h06, 8'h51, 8'h52, 8'h53};
    checks++; if (got != exp_q) begin failures++; $display("FAIL rstmid_prefix got %p exp %p", got, exp_q); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL rstmid_tx_valid got %0b exp 0", tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %0b exp 0", busy); end
    checks++; if (rdreq !== 8'h00) begin failures++; $display("FAIL rstmid_rdreq got %b exp 0", rdreq); end
    checks++; if (cur_src !== 3'd0) begin failures++; $display("FAIL rstmid_cur_src got %0d exp 0", cur_src); end
    checks++; if (rd_cnt[4] - b4 != 3) begin failures++; $display("FAIL rstmid_pops got %0d exp 3", rd_cnt[4] - b4); end
    got.delete(); grants.delete();
    set_len(2, 8'd0);
    have_msg = 8'b0100_0100;
    run_pkt(100, ok);
    checks++; if (!ok) begin failures++; $display("FAIL rstmid_timeout got %0b exp 1", ok); end
    checks++; if (grants.size() < 1 || grants[0] != 2) begin failures++; $display("FAIL rstmid_grant got %p exp 2", grants); end
    exp_q = '{8'hDD, 8'h12, 8'h00, 8'h12};
    checks++; if (got != exp_q) begin failures++; $display("FAIL rstmid_frame got %p exp %p", got, exp_q); end
  endtask

  initial begin
    rst = 1'b1; have_msg = '0; len_bus = '0; tx_ready = 1'b1;
    test_reset();
    test_single();
    test_zero_len();
    test_round_robin();
    test_backpressure();
    test_late_request();
    test_reset_mid_payload();
    checks++; if (onehot_bad != 0) begin failures++; $display("FAIL rdreq_onehot got %0d bad cycles exp 0", onehot_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
